// File: rtl/alu_operand_regfile.sv
// Register file and registered operand-issue stage feeding the ALU (R2/R3 via valid/ready).
// Optional write-through forwarding of a same-cycle write-back is enabled by defining REGFILE_BYPASS_EN.
module alu_operand_regfile #(
  parameter int word_size = 32,
  parameter int addr_size = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_req,
  output logic                 rd_ready,
  input  logic [addr_size-1:0] src_a,
  input  logic [addr_size-1:0] src_b,
  output logic [word_size-1:0] R2,
  output logic [word_size-1:0] R3,
  output logic                 op_valid,
  input  logic                 op_ready,
  input  logic                 wr_en,
  input  logic [addr_size-1:0] wr_addr,
  input  logic [word_size-1:0] wr_data
);

  localparam int DEPTH = 2 ** addr_size;

  logic [word_size-1:0] r_regs [DEPTH];
  logic [word_size-1:0] r_R2;
  logic [word_size-1:0] r_R3;
  logic                 r_valid;

  logic                 w_accept;
  logic                 w_wrActive;
  logic [word_size-1:0] w_rdA;
  logic [word_size-1:0] w_rdB;

  assign rd_ready   = !r_valid || op_ready;
  assign w_accept   = rd_req && rd_ready;
  assign w_wrActive = wr_en && (wr_addr != '0);

  // Address 0 is hard-wired to zero on the read side, so its storage is never consulted.
  always_comb begin
    w_rdA = (src_a == '0) ? '0 : r_regs[src_a];
    w_rdB = (src_b == '0) ? '0 : r_regs[src_b];
`ifdef REGFILE_BYPASS_EN
    if (w_wrActive && (wr_addr == src_a)) w_rdA = wr_data;
    if (w_wrActive && (wr_addr == src_b)) w_rdB = wr_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wrActive) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Operands are snapshots: once captured they only change on the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_R2    <= '0;
      r_R3    <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_R2    <= w_rdA;
      r_R3    <= w_rdB;
      r_valid <= 1'b1;
    end else if (r_valid && op_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign R2       = r_R2;
  assign R3       = r_R3;
  assign op_valid = r_valid;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Self-checking bench for alu_operand_regfile: directed scenarios plus random traffic against a behavioural model.
// Honours REGFILE_BYPASS_EN in its expectations.
module tb_alu_operand_regfile;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic        rd_ready;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic [31:0] R2;
  logic [31:0] R3;
  logic        op_valid;
  logic        op_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the register contents and the operand pair the ALU should see.
  logic [31:0] mRegs [32];
  logic [31:0] mR2;
  logic [31:0] mR3;
  logic        mValid;

  alu_operand_regfile #(.word_size(32), .addr_size(5)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_ready(rd_ready),
    .src_a(src_a), .src_b(src_b), .R2(R2), .R3(R3),
    .op_valid(op_valid), .op_ready(op_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == addr) return wr_data;
`endif
    return mRegs[addr];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mR2 = 32'd0;
    mR3 = 32'd0;
    mValid = 1'b0;
  endtask

  // One clock with current inputs; checks rd_ready before the edge and the pair after it.
  task automatic applyStimulus();
    logic        rdy;
    logic        acc;
    logic [31:0] na;
    logic [31:0] nb;
    #1;
    rdy = !mValid || op_ready;
    acc = rd_req && rdy;
    checkOutput("rd_ready", {31'd0, rd_ready}, {31'd0, rdy});
    na = modelRead(src_a);
    nb = modelRead(src_b);
    @(posedge clk);
    if (wr_en && wr_addr != 5'd0) mRegs[wr_addr] = wr_data;
    if (acc) begin
      mR2 = na;
      mR3 = nb;
      mValid = 1'b1;
    end else if (mValid && op_ready) begin
      mValid = 1'b0;
    end
    #1;
    checkOutput("R2", R2, mR2);
    checkOutput("R3", R3, mR3);
    checkOutput("op_valid", {31'd0, op_valid}, {31'd0, mValid});
  endtask

  task automatic idleInputs();
    rd_req = 0; op_ready = 0; wr_en = 0;
    src_a = 0; src_b = 0; wr_addr = 0; wr_data = 0;
  endtask

  initial begin
    int run;
    idleInputs();
    modelReset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_R2", R2, 32'd0);
    checkOutput("reset_R3", R3, 32'd0);
    checkOutput("reset_valid", {31'd0, op_valid}, 32'd0);
    rst_n = 1;

    // Write r5/r6 then issue them.
    wr_en = 1; wr_addr = 5; wr_data = 32'h0000_0007; applyStimulus();
    wr_addr = 6; wr_data = 32'hFFFF_FFF9; applyStimulus();
    wr_en = 0; rd_req = 1; src_a = 5; src_b = 6; op_ready = 0; applyStimulus();
    checkOutput("issue_R2", R2, 32'h0000_0007);
    checkOutput("issue_R3", R3, 32'hFFFF_FFF9);
    checkOutput("issue_valid", {31'd0, op_valid}, 32'd1);

    // Stall while r5 is overwritten; the captured operand must not move.
    wr_en = 1; wr_addr = 5; wr_data = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stall_R2", R2, 32'h0000_0007);
      checkOutput("stall_rd_ready", {31'd0, rd_ready}, 32'd0);
    end
    wr_en = 0; rd_req = 0; op_ready = 1; applyStimulus();
    checkOutput("consume_valid", {31'd0, op_valid}, 32'd0);
    rd_req = 1; src_a = 5; src_b = 5; applyStimulus();
    checkOutput("r5_updated", R2, 32'h0000_0001);

    // Same-cycle write and read of r9.
    wr_en = 1; wr_addr = 9; wr_data = 32'hA5A5_A5A5; src_a = 9; src_b = 6; applyStimulus();
`ifdef REGFILE_BYPASS_EN
    checkOutput("collide_R2", R2, 32'hA5A5_A5A5);
`else
    checkOutput("collide_R2", R2, 32'h0000_0000);
`endif
    wr_en = 0; applyStimulus();
    checkOutput("r9_next", R2, 32'hA5A5_A5A5);

    // r0 ignores writes, including same-cycle ones.
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; src_a = 0; src_b = 0; applyStimulus();
    checkOutput("r0_same_R2", R2, 32'd0);
    wr_en = 0; applyStimulus();
    checkOutput("r0_R2", R2, 32'd0);
    checkOutput("r0_R3", R3, 32'd0);

    // Fill r1..r31 with distinct values, then stream 8 back-to-back pairs.
    rd_req = 0; wr_en = 1;
    for (int i = 1; i < 32; i++) begin
      wr_addr = 5'(i); wr_data = {11'(i), 21'($urandom)};
      applyStimulus();
    end
    wr_en = 0; rd_req = 1; op_ready = 1;
    for (int i = 0; i < 8; i++) begin
      src_a = 5'(i + 1); src_b = 5'(i + 17);
      applyStimulus();
      checkOutput("stream_valid", {31'd0, op_valid}, 32'd1);
      checkOutput("stream_R2_tag", {21'd0, R2[31:21]}, 32'(i + 1));
      checkOutput("stream_R3_tag", {21'd0, R3[31:21]}, 32'(i + 17));
    end

    // Random traffic against the model.
    for (run = 0; run < 300; run++) begin
      rd_req   = 1'($urandom);
      op_ready = ($urandom_range(0, 3) != 0);
      wr_en    = 1'($urandom);
      src_a    = 5'($urandom);
      src_b    = ($urandom_range(0, 7) == 0) ? src_a : 5'($urandom);
      wr_addr  = ($urandom_range(0, 3) == 0) ? src_a : 5'($urandom);
      wr_data  = $urandom;
      applyStimulus();
    end

    // Async reset in the middle of a stall with a live pair.
    wr_en = 0; rd_req = 1; op_ready = 0; src_a = 5; src_b = 9; applyStimulus();
    rd_req = 0; applyStimulus();
    checkOutput("prereset_valid", {31'd0, op_valid}, 32'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("async_R2", R2, 32'd0);
    checkOutput("async_R3", R3, 32'd0);
    checkOutput("async_valid", {31'd0, op_valid}, 32'd0);
    modelReset();
    @(posedge clk);
    #1 rst_n = 1;
    rd_req = 1; op_ready = 1;
    for (int i = 0; i < 32; i += 2) begin
      src_a = 5'(i); src_b = 5'(i + 1);
      applyStimulus();
      checkOutput("postreset_R2", R2, 32'd0);
      checkOutput("postreset_R3", R3, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
